// File: rtl/bus_arbiter_rr_if.sv
// Signal bundle between the two cores / L2 controller and the round-robin bus arbiter.
// master = requester/L2 side, slave = arbiter side.
interface bus_arbiter_rr_if;
   logic req_core1;
   logic req_core2;
   logic flush_in1;
   logic flush_in2;
   logic l2_busy;
   logic grant_core1;
   logic grant_core2;
   logic stall_core1;
   logic stall_core2;
   logic sel_core;
   logic flush_out;
   logic last_owner;

   modport master (
      output req_core1, req_core2, flush_in1, flush_in2, l2_busy,
      input  grant_core1, grant_core2, stall_core1, stall_core2,
             sel_core, flush_out, last_owner
   );

   modport slave (
      input  req_core1, req_core2, flush_in1, flush_in2, l2_busy,
      output grant_core1, grant_core2, stall_core1, stall_core2,
             sel_core, flush_out, last_owner
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Two-core round-robin arbiter for the snoop bus / L2 port, flush requests take priority.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input logic             clk,
   input logic             reset,
   bus_arbiter_rr_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN1  = 2'd1,
      OWN2  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic grant1_q;
   logic grant2_q;
   logic sel_q;
   logic flush_q;
   logic last_q;

   logic any_req;
   logic win_core;
   logic win_flush;
   logic take;
   logic preempt1;
   logic preempt2;

   // Winner if a grant were issued this cycle: 0 = core1, 1 = core2
   always_comb begin
      any_req  = bus.req_core1 | bus.req_core2;
      win_core = bus.req_core2;
      if (bus.req_core1 && bus.req_core2) begin
         if (bus.flush_in1 != bus.flush_in2) begin
            win_core = bus.flush_in2;
         end else begin
            win_core = ~last_q;
         end
      end
      win_flush = win_core ? bus.flush_in2 : bus.flush_in1;
   end

   // The DRAIN exit cycle arbitrates like IDLE so a deferred request is granted
   // one cycle after l2_busy falls.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            take = any_req;
         end
         OWN1: begin
            if (!bus.req_core1 || preempt1) begin
               state_nxt = bus.l2_busy ? DRAIN : IDLE;
            end
         end
         OWN2: begin
            if (!bus.req_core2 || preempt2) begin
               state_nxt = bus.l2_busy ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (!bus.l2_busy) begin
               take      = any_req;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (take) begin
         state_nxt = win_core ? OWN2 : OWN1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant1_q <= 1'b0;
         grant2_q <= 1'b0;
         sel_q    <= 1'b0;
         flush_q  <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         state    <= state_nxt;
         grant1_q <= (state_nxt == OWN1);
         grant2_q <= (state_nxt == OWN2);
         flush_q  <= take & win_flush;
         if (take) begin
            sel_q  <= win_core;
            last_q <= win_core;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] wait_cnt1;
   logic [CNT_W-1:0] wait_cnt2;
   logic             hold_max;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // hold_cnt is the number of owned cycles already completed in this ownership
   assign hold_max = (hold_cnt >= CNT_W'(MAX_HOLD - 1));
   assign preempt1 = hold_max & bus.req_core2;
   assign preempt2 = hold_max & bus.req_core1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt  <= '0;
         wait_cnt1 <= '0;
         wait_cnt2 <= '0;
      end else begin
         if ((state == OWN1 || state == OWN2) && state_nxt == state) begin
            hold_cnt <= sat_inc(hold_cnt);
         end else begin
            hold_cnt <= '0;
         end
         if (bus.stall_core1) begin
            wait_cnt1 <= sat_inc(wait_cnt1);
         end
         if (bus.stall_core2) begin
            wait_cnt2 <= sat_inc(wait_cnt2);
         end
      end
   end
`else
   assign preempt1 = 1'b0;
   assign preempt2 = 1'b0;
`endif

   assign bus.grant_core1 = grant1_q;
   assign bus.grant_core2 = grant2_q;
   assign bus.sel_core    = sel_q;
   assign bus.flush_out   = flush_q;
   assign bus.last_owner  = last_q;
   assign bus.stall_core1 = bus.req_core1 & ~grant1_q;
   assign bus.stall_core2 = bus.req_core2 & ~grant2_q;

   grant_excl: assert property (@(posedge clk) disable iff (reset)
      !(grant1_q && grant2_q));

   param_range: assert property (@(posedge clk)
      (MAX_HOLD >= 2) && (MAX_HOLD <= 255) && ((CNT_W >= 8) || (MAX_HOLD < (32'd1 << CNT_W))));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: a behavioural model queues expected outputs per cycle.
module tb_bus_arbiter_rr;

   localparam int MAX_HOLD_TB = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TIMEOUT = 1'b1;
`else
   localparam bit TIMEOUT = 1'b0;
`endif
   localparam int S_IDLE  = 0;
   localparam int S_OWN1  = 1;
   localparam int S_OWN2  = 2;
   localparam int S_DRAIN = 3;

   typedef struct packed {
      logic g1;
      logic g2;
      logic sel;
      logic flush;
      logic last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   bus_arbiter_rr_if bus();

   bus_arbiter_rr #(.MAX_HOLD(MAX_HOLD_TB), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   int   m_state;
   int   m_hold;
   logic m_g1, m_g2, m_sel, m_flush, m_last;

   task automatic chk_eq(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE;
      m_hold  = 0;
      m_g1    = 1'b0;
      m_g2    = 1'b0;
      m_sel   = 1'b0;
      m_flush = 1'b0;
      m_last  = 1'b1;
   endtask

   // Reference behaviour for one clock edge given this cycle's inputs
   task automatic model_step(input logic r1, input logic r2, input logic f1,
                             input logic f2, input logic busy);
      logic who;
      logic take;
      logic rel;
      take = 1'b0;
      rel  = 1'b0;
      if (r1 != r2)      who = r2;
      else if (f1 != f2) who = f2;
      else               who = ~m_last;
      if (m_state == S_OWN1 || m_state == S_OWN2) m_hold++;
      case (m_state)
         S_IDLE: take = r1 | r2;
         S_OWN1: rel  = !r1 || (TIMEOUT && m_hold >= MAX_HOLD_TB && r2);
         S_OWN2: rel  = !r2 || (TIMEOUT && m_hold >= MAX_HOLD_TB && r1);
         default: begin
            if (!busy) begin
               take    = r1 | r2;
               m_state = S_IDLE;
            end
         end
      endcase
      if (rel) m_state = busy ? S_DRAIN : S_IDLE;
      m_flush = 1'b0;
      if (take) begin
         m_state = who ? S_OWN2 : S_OWN1;
         m_sel   = who;
         m_last  = who;
         m_flush = who ? f2 : f1;
         m_hold  = 0;
      end
      m_g1 = (m_state == S_OWN1);
      m_g2 = (m_state == S_OWN2);
   endtask

   task automatic cyc(input logic r1, input logic r2, input logic f1,
                      input logic f2, input logic busy);
      exp_t e;
      bus.req_core1 = r1;
      bus.req_core2 = r2;
      bus.flush_in1 = f1;
      bus.flush_in2 = f2;
      bus.l2_busy   = busy;
      #1;
      chk_eq("stall_core1", bus.stall_core1, r1 & ~m_g1);
      chk_eq("stall_core2", bus.stall_core2, r2 & ~m_g2);
      model_step(r1, r2, f1, f2, busy);
      e.g1    = m_g1;
      e.g2    = m_g2;
      e.sel   = m_sel;
      e.flush = m_flush;
      e.last  = m_last;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk_eq("grant_core1", bus.grant_core1, e.g1);
      chk_eq("grant_core2", bus.grant_core2, e.g2);
      chk_eq("sel_core",    bus.sel_core,    e.sel);
      chk_eq("flush_out",   bus.flush_out,   e.flush);
      chk_eq("last_owner",  bus.last_owner,  e.last);
   endtask

   task automatic do_reset();
      bus.req_core1 = 1'b0;
      bus.req_core2 = 1'b0;
      bus.flush_in1 = 1'b0;
      bus.flush_in2 = 1'b0;
      bus.l2_busy   = 1'b0;
      reset = 1'b1;
      model_reset();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   int  own1;
   logic run1;

   initial begin
      do_reset();
      chk_eq("rst_grant_core1", bus.grant_core1, 1'b0);
      chk_eq("rst_grant_core2", bus.grant_core2, 1'b0);
      chk_eq("rst_sel_core",    bus.sel_core,    1'b0);
      chk_eq("rst_flush_out",   bus.flush_out,   1'b0);
      chk_eq("rst_last_owner",  bus.last_owner,  1'b1);

      // single requester, one-cycle latency
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk_eq("single_grant1", bus.grant_core1, 1'b1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // simultaneous plain requests alternate
      do_reset();
      cyc(1, 1, 0, 0, 0);
      chk_eq("tie_first_core1", bus.grant_core1, 1'b1);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk_eq("tie_then_core2", bus.grant_core2, 1'b1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk_eq("tie_again_core1", bus.grant_core1, 1'b1);
      cyc(0, 0, 0, 0, 0);

      // flush beats plain
      do_reset();
      cyc(1, 1, 0, 1, 0);
      chk_eq("flush_win_sel", bus.sel_core, 1'b1);
      chk_eq("flush_pulse", bus.flush_out, 1'b1);
      cyc(1, 1, 0, 1, 0);
      chk_eq("flush_one_cycle", bus.flush_out, 1'b0);
      cyc(1, 1, 0, 1, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // release while L2 busy: drain, then deferred request
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 1);
         chk_eq("drain_no_grant", bus.grant_core2, 1'b0);
         chk_eq("drain_sel_held", bus.sel_core, 1'b0);
      end
      cyc(0, 1, 0, 0, 0);
      chk_eq("drain_exit_grant2", bus.grant_core2, 1'b1);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      chk_eq("withdrawn_no_grant", bus.grant_core1, 1'b0);
      cyc(0, 0, 0, 0, 0);

      // asynchronous reset during core2 ownership
      do_reset();
      cyc(0, 1, 0, 1, 0);
      chk_eq("pre_rst_grant2", bus.grant_core2, 1'b1);
      reset = 1'b1;
      #1;
      chk_eq("async_rst_grant2", bus.grant_core2, 1'b0);
      chk_eq("async_rst_flush", bus.flush_out, 1'b0);
      chk_eq("async_rst_last", bus.last_owner, 1'b1);
      model_reset();
      bus.req_core2 = 1'b0;
      bus.flush_in2 = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(1, 1, 0, 0, 0);
      chk_eq("post_rst_core1", bus.grant_core1, 1'b1);
      cyc(0, 0, 0, 0, 0);

      // long hold by core1 with core2 waiting
      do_reset();
      cyc(1, 0, 0, 0, 0);
      own1 = 1;
      run1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (!bus.grant_core1) run1 = 1'b0;
         if (run1) own1++;
      end
`ifdef ARB_TIMEOUT_EN
      chk_eq("timeout_hold_4", own1 == MAX_HOLD_TB, 1'b1);
`endif
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Two-requester arbiter and sequencer for the shared snoop bus and the L2 port between cpu1 and cpu2.
- Sits between the cores' req/flush outputs and the bus controller. Drives the grants and stalls, the L2 flush strobe, and the select for the L2 write-data/tag mux.
- Fair round-robin between the cores. A flush (write-back) request has priority over a plain request.
- Ownership holds until the owner releases and the L2 transaction drains.

Parameters:
- MAX_HOLD, 16: maximum consecutive owned cycles before forced release (timeout feature only); legal range 2..255.
- CNT_W, 8: width of the hold and statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_core1  in  1  core 1 requests the bus
- req_core2  in  1  core 2 requests the bus
- flush_in1  in  1  core 1 request is an L2 write-back
- flush_in2  in  1  core 2 request is an L2 write-back
- l2_busy  in  1  L2/dmem transaction outstanding
- grant_core1  out  1  core 1 owns the bus (registered)
- grant_core2  out  1  core 2 owns the bus (registered)
- stall_core1  out  1  core 1 must hold its pipeline
- stall_core2  out  1  core 2 must hold its pipeline
- sel_core  out  1  data/tag mux select to L2: 0 = core1, 1 = core2 (registered)
- flush_out  out  1  write-back strobe to L2, one cycle per granted flush
- last_owner  out  1  last core granted (0 = core1), for debug

Behaviour:
- Reset values: grant_core1=0, grant_core2=0, sel_core=0, flush_out=0, last_owner=1 (so core1 wins the first tie), FSM=IDLE, all counters 0.
- States: IDLE, OWN1, OWN2, DRAIN.
- IDLE arbitration:
  - Requests are sampled at edge N; the grant is visible after edge N+1, i.e. one-cycle latency.
  - A single requester wins.
  - If both request: a requester with flush_in set beats one without.
  - If both are flush, or both are plain: the core != last_owner wins.
  - On grant: last_owner updates, sel_core is set, and the FSM goes to OWNx.
- OWNx:
  - grant_corex stays high while req_corex is high.
  - flush_out pulses high for exactly the first owned cycle when flush_inx was set at grant. It never re-pulses within the same ownership.
- Release:
  - If req_corex drops and l2_busy=0: grant deasserts on the next edge and the FSM returns to IDLE. That same IDLE cycle may grant the other core.
  - If req_corex drops and l2_busy=1: go to DRAIN. Grant deasserts, sel_core is held, and no new grant is issued.
- DRAIN: wait for l2_busy=0, then IDLE. A new request arriving in DRAIN is deferred, not lost.
- Stall: stall_corex = req_corex AND NOT grant_corex (combinational on the registered grant). A requester is therefore stalled in its request cycle and in every waiting cycle.
- Grant exclusivity: grant_core1 and grant_core2 are never both 1; assertion required.
- Request deassertion before grant: the request is withdrawn and no grant is issued.
- Reset mid-ownership: grants drop immediately (asynchronous), flush_out clears, and the FSM is IDLE on the first edge after reset deasserts.
- Counter widths: counters saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A hold counter increments each OWNx cycle.
  - If it reaches MAX_HOLD while the other core requests, ownership is force-released: grant drops and the FSM goes to DRAIN (if l2_busy) or IDLE. The other core is granted next.
  - The preempted core sees stall_corex=1 until it is re-granted.
  - A sticky wait counter per core (saturating) is added for debug.
- ARB_TIMEOUT_EN undefined: no preemption; ownership lasts until the owner releases. Counter logic is absent.

Test Plan:
- Reset, then req_core1=1 at cycle 2 -> grant_core1=1 from cycle 3, sel_core=0, stall_core1=1 only in cycle 2, flush_out=0.
- Both cores request plain in the same cycle after reset -> core1 granted first (last_owner reset=1). After core1 releases, core2 is granted in the following IDLE cycle; a second simultaneous pair goes to core1 again.
- core1 plain and core2 flush simultaneously -> core2 granted, sel_core=1, flush_out high for exactly one cycle, stall_core1=1 throughout.
- Owner drops req while l2_busy=1 for 5 cycles -> FSM in DRAIN, no grant for 5 cycles. Next grant occurs 1 cycle after l2_busy falls; sel_core held during DRAIN.
- Assert reset while grant_core2=1 -> grant_core2=0 in the same cycle with no clock edge; after release, the first request is served with last_owner=1 behaviour.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: core1 holds req, core2 requests -> core1 grant drops after 4 owned cycles, core2 granted next, stall_core1=1 until re-granted.
